// File: rtl/stoch_sub_mat_eval_ctrl.sv
// Evaluation-window sequencer for a stochastic signed matrix subtractor:
// flushes the array, skips warm-up, integrates Y_p - Y_m per element with
// symmetric saturation, then hands the counts to a consumer via done/ack.
module stoch_sub_mat_eval_ctrl #(
    parameter int unsigned NUM_ROWS     = 2,
    parameter int unsigned NUM_COLS     = 2,
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned ACC_W        = 18,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned SUB_LAT      = 1
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         start,
    input  logic [LEN_W-1:0]                             len,
    input  logic                                         ack,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]            Y_p,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]            Y_m,
    output logic                                         sub_nrst,
    output logic                                         stream_en,
    output logic                                         busy,
    output logic                                         done,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0] acc
);

    // Phase counter must hold the longest of the flush, warm-up and run lengths
    localparam int unsigned PH_MAX = (FLUSH_CYCLES > SUB_LAT) ? FLUSH_CYCLES : SUB_LAT;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned CNT_W  = (LEN_W > PH_W) ? LEN_W : PH_W;

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARM_LOAD  = CNT_W'((SUB_LAT == 0) ? 0 : SUB_LAT - 1);

    // Symmetric saturation limits: +(2^(ACC_W-1)-1) and its negation
    localparam logic [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

    typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0] acc_arr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_WARM  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    acc_arr_t           acc_q, acc_d;
    logic               sub_nrst_q, sub_nrst_d;
    logic               stream_en_q, stream_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   run_load_c;

    // Run phase counts down from len-1; len==0 never reaches RUN
    assign run_load_c = CNT_W'(len_q) - CNT_W'(1);

    // State, counters, accumulators and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            sub_nrst_q  <= 1'b0;
            stream_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            sub_nrst_q  <= sub_nrst_d;
            stream_en_q <= stream_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, phase counting, saturating integration and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_d       = acc_q;
        sub_nrst_d  = 1'b0;
        stream_en_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    if (SUB_LAT == 0) begin
                        cnt_d   = run_load_c;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = WARM_LOAD;
                        state_d = ST_WARM;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WARM: begin
                if (cnt_q == '0) begin
                    cnt_d   = run_load_c;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                    for (int unsigned c = 0; c < NUM_COLS; c++) begin
                        if (Y_p[r][c] && !Y_m[r][c] && (acc_q[r][c] != ACC_POS)) begin
                            acc_d[r][c] = acc_q[r][c] + ACC_W'(1);
                        end else if (!Y_p[r][c] && Y_m[r][c] && (acc_q[r][c] != ACC_NEG)) begin
                            acc_d[r][c] = acc_q[r][c] - ACC_W'(1);
                        end
                    end
                end
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (ack) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        sub_nrst_d  = (state_d == ST_WARM) || (state_d == ST_RUN);
        stream_en_d = (state_d == ST_FLUSH) || (state_d == ST_WARM) || (state_d == ST_RUN);
        busy_d      = stream_en_d;
        done_d      = (state_d == ST_DONE);
    end

    assign sub_nrst  = sub_nrst_q;
    assign stream_en = stream_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_stoch_sub_mat_eval_ctrl.sv
// Self-checking bench: random and directed evaluation windows compared with a
// cycle-timeline reference model (phase boundaries and clamped sums).
module tb_stoch_sub_mat_eval_ctrl;

    localparam int unsigned R   = 2;
    localparam int unsigned C   = 2;
    localparam int unsigned LW  = 16;
    localparam int unsigned AW  = 18;
    localparam int unsigned F   = 2;
    localparam int unsigned S   = 1;
    localparam int unsigned AWS = 4;

    typedef logic [R-1:0][C-1:0] lane_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst, start, ack;
    logic [LW-1:0]             len;
    lane_t                     yp, ym;
    logic                      sub_nrst, stream_en, busy, done;
    logic [R-1:0][C-1:0][AW-1:0] acc;

    logic                       start_s, ack_s;
    logic [LW-1:0]              len_s;
    lane_t                      yp_s, ym_s;
    logic                       sub_nrst_s, stream_en_s, busy_s, done_s;
    logic [R-1:0][C-1:0][AWS-1:0] acc_s;

    int     checks = 0;
    int     errors = 0;
    longint exp_acc [R][C];

    stoch_sub_mat_eval_ctrl #(
        .NUM_ROWS(R), .NUM_COLS(C), .LEN_W(LW), .ACC_W(AW),
        .FLUSH_CYCLES(F), .SUB_LAT(S)
    ) dut (
        .CLK(clk), .RST(rst), .start(start), .len(len), .ack(ack),
        .Y_p(yp), .Y_m(ym), .sub_nrst(sub_nrst), .stream_en(stream_en),
        .busy(busy), .done(done), .acc(acc)
    );

    stoch_sub_mat_eval_ctrl #(
        .NUM_ROWS(R), .NUM_COLS(C), .LEN_W(LW), .ACC_W(AWS),
        .FLUSH_CYCLES(F), .SUB_LAT(S)
    ) dut_s (
        .CLK(clk), .RST(rst), .start(start_s), .len(len_s), .ack(ack_s),
        .Y_p(yp_s), .Y_m(ym_s), .sub_nrst(sub_nrst_s), .stream_en(stream_en_s),
        .busy(busy_s), .done(done_s), .acc(acc_s)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat_add(input longint a, input longint d, input int unsigned w);
        longint lim = (longint'(1) <<< (w - 1)) - 1;
        longint s   = a + d;
        if (s > lim)  s = lim;
        if (s < -lim) s = -lim;
        return s;
    endfunction

    // Stream pattern for run index j (j<0: non-accumulating cycle, random junk)
    task automatic gen_y(input int mode, input int j, output lane_t p, output lane_t m);
        p = lane_t'($urandom);
        m = lane_t'($urandom);
        if (j >= 0 && mode == 1) begin
            p = '0; m = '0;
            p[0][0] = 1'b1;
        end else if (j >= 0 && mode == 2) begin
            p = '0; m = '0;
            if (j < 60) begin p[1][1] = 1'b0; m[1][1] = 1'b1; end
            else        begin p[1][1] = 1'b1; m[1][1] = 1'b1; end
            p[0][1] = (j % 2 == 0);
            m[0][1] = (j % 2 != 0);
        end
    endtask

    task automatic check_acc(input string tag);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                check($sformatf("%s[%0d][%0d]", tag, r, c), longint'($signed(acc[r][c])), exp_acc[r][c]);
    endtask

    // After k edges past the accepting edge, a window of total length t is
    // in FLUSH for k<F, WARM for k<F+S, RUN for k<t, DONE at k==t
    task automatic observe(input int k, input int t, input bit full);
        check($sformatf("done@%0d", k), longint'(done), longint'(k == t));
        if (full || k == t) begin
            check($sformatf("busy@%0d", k), longint'(busy), longint'(k < t));
            check($sformatf("sub_nrst@%0d", k), longint'(sub_nrst), longint'(k >= F && k < t));
            check($sformatf("stream_en@%0d", k), longint'(stream_en), longint'(k < t));
        end
    endtask

    task automatic run_window(input int l, input int mode, input bit disturb);
        int    t;
        lane_t p, m;
        bit    both;
        logic [R-1:0][C-1:0][AW-1:0] held;
        t = (l == 0) ? 0 : int'(F + S) + l;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                exp_acc[r][c] = 0;
        @(negedge clk);
        start = 1'b1; ack = 1'b0; len = LW'(l);
        @(negedge clk);
        start = 1'b0; len = LW'($urandom);
        observe(0, t, 1'b1);
        for (int k = 1; k <= t; k++) begin
            gen_y(mode, k - int'(F + S) - 1, p, m);
            yp = p; ym = m;
            start = disturb && l >= 4 && k == int'(F + S) + 2;
            ack   = start;
            @(negedge clk);
            start = 1'b0; ack = 1'b0;
            if (k > int'(F + S))
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        exp_acc[r][c] = sat_add(exp_acc[r][c],
                            longint'(p[r][c] && !m[r][c]) - longint'(!p[r][c] && m[r][c]), AW);
            observe(k, t, l < 1000);
        end
        yp = '0; ym = '0;
        check_acc("acc");
        held = acc;
        // start while DONE is ignored; results hold
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("done_hold", longint'(done), 1);
        check("busy_in_done", longint'(busy), 0);
        check("acc_hold", longint'(acc == held), 1);
        both  = 1'($urandom_range(0, 1));
        start = both; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        check("done_after_ack", longint'(done), 0);
        check("busy_after_ack", longint'(busy), 0);
        @(negedge clk);
        check("idle_stays", longint'(busy | done | stream_en | sub_nrst), 0);
        check("acc_retained", longint'(acc == held), 1);
    endtask

    task automatic sat_window(input bit pos);
        int     n;
        longint e;
        e = 0;
        for (int i = 0; i < 20; i++) e = sat_add(e, pos ? 1 : -1, AWS);
        @(negedge clk);
        start_s = 1'b1; len_s = LW'(20);
        yp_s = pos ? '1 : '0; ym_s = pos ? '0 : '1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!done_s && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sat_latency", n, int'(F + S) + 20);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                check($sformatf("sat_acc[%0d][%0d]", r, c), longint'($signed(acc_s[r][c])), e);
        ack_s = 1'b1;
        @(negedge clk);
        ack_s = 1'b0;
        check("sat_idle", longint'(done_s | busy_s), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; len = '0; yp = '0; ym = '0;
        start_s = 1'b0; ack_s = 1'b0; len_s = '0; yp_s = '0; ym_s = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        yp = lane_t'($urandom); ym = lane_t'($urandom);
        repeat (10) @(negedge clk);
        for (int r = 0; r < R; r++) exp_acc[r] = '{default: 0};
        check_acc("rst_acc");
        check("rst_done", longint'(done), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_sub_nrst", longint'(sub_nrst), 0);
        check("rst_stream_en", longint'(stream_en), 0);
        check("rst_sat_acc", longint'(acc_s), 0);
        yp = '0; ym = '0;

        run_window(8, 1, 1'b0);
        run_window(100, 2, 1'b0);
        for (int i = 0; i < 6; i++)
            run_window($urandom_range(1, 40), 0, 1'($urandom_range(0, 1)));
        run_window(12, 0, 1'b1);
        run_window(0, 0, 1'b0);

        sat_window(1'b1);
        sat_window(1'b0);

        // Reset in the middle of a window
        @(negedge clk);
        start = 1'b1; len = LW'(50);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= int'(F + S) + 5; k++) begin
            yp = '0; ym = '0; yp[0][0] = 1'b1;
            @(negedge clk);
        end
        check("pre_rst_acc", longint'($signed(acc[0][0])), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; yp = '0; ym = '0;
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
        check("mid_rst_sub_nrst", longint'(sub_nrst), 0);
        check("mid_rst_stream_en", longint'(stream_en), 0);
        for (int r = 0; r < R; r++) exp_acc[r] = '{default: 0};
        check_acc("mid_rst_acc");
        @(negedge clk);
        check("mid_rst_idle", longint'(busy), 0);
        run_window(4, 0, 1'b0);

        run_window((1 << LW) - 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stoch_sub_mat_eval_ctrl.md
Name: stoch_sub_mat_eval_ctrl

Overview:
- Sequences one evaluation window of a stochastic signed matrix subtractor (NUM_ROWS x NUM_COLS lanes of p/m bitstream pairs).
- Holds the datapath in reset and flushes it, enables upstream bitstream generators, and discards the warm-up cycles.
- Then integrates each element's signed output (Y_p - Y_m) over a programmable number of cycles and presents the per-element counts to a consumer via a done/ack handshake.
- Sits between the software-facing control interface and the subtractor array.

Parameters:
- NUM_ROWS, 2, matrix rows.
- NUM_COLS, 2, matrix columns.
- LEN_W, 16, width of window-length input.
- ACC_W, 18, width of each signed accumulator (two's complement).
- FLUSH_CYCLES, 2, cycles datapath is held in reset after start (>=1).
- SUB_LAT, 1, warm-up cycles after reset release that are not accumulated (>=0).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request a new evaluation window.
- len  in  LEN_W  window length in cycles, sampled when start is accepted.
- ack  in  1  consumer has taken results.
- Y_p  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  subtractor plus streams.
- Y_m  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  subtractor minus streams.
- sub_nrst  out  1  active-low reset driven to the subtractor array.
- stream_en  out  1  enable for upstream bitstream generators.
- busy  out  1  high in FLUSH/WARM/RUN.
- done  out  1  results valid (DONE state).
- acc  out  [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0]  signed per-element counts.

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-window): state=IDLE, all acc=0, done=0, busy=0, sub_nrst=0, stream_en=0, internal counters=0. RST has priority over all other inputs.
- States: IDLE, FLUSH, WARM, RUN, DONE. All outputs are registered or decoded from state; Y_p/Y_m are sampled on the same edge as accumulation.
- IDLE:
  - sub_nrst=0, stream_en=0.
  - start=1 and len!=0: latch len, clear all acc, go to FLUSH.
  - start=1 and len==0: clear acc, go directly to DONE.
- FLUSH: sub_nrst=0, stream_en=1, busy=1. Stays exactly FLUSH_CYCLES cycles, then goes to WARM (or RUN if SUB_LAT==0).
- WARM: sub_nrst=1, stream_en=1. Stays exactly SUB_LAT cycles; Y inputs are ignored. Then goes to RUN.
- RUN: sub_nrst=1, stream_en=1. Stays exactly latched-len cycles; each cycle every element updates:
  - acc += +1 if (Y_p,Y_m)=(1,0);
  - acc += -1 if (0,1);
  - else +0.
  - After the len-th accumulating edge, go to DONE.
- Saturation: acc saturates at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)-1); it never wraps.
- DONE:
  - done=1, busy=0, sub_nrst=0, stream_en=0; acc held stable.
  - ack=1 returns to IDLE on the next edge. acc retains its values in IDLE until the next accepted start.
- Total latency from start edge to done=1: FLUSH_CYCLES+SUB_LAT+len cycles (1 cycle for len==0).
- Boundary rules:
  - start while busy or in DONE is ignored (no queuing); start and ack in the same DONE cycle means ack only.
  - ack outside DONE is ignored.
  - len changes after acceptance have no effect.
  - len at its maximum (2^LEN_W-1) must run the full count without counter wrap.

Test Plan:
- Reset then idle, 10 cycles -> acc all 0, done=0, busy=0, sub_nrst=0, stream_en=0.
- Defaults, start with len=8, Y_p[0][0]=1/Y_m[0][0]=0 constant, all other elements 0/0 -> done rises exactly 11 cycles after the start edge; acc[0][0]=+8, others 0; sub_nrst low for the first 2 busy cycles.
- len=100, element [1][1] driven Y_p=0/Y_m=1 for 60 cycles and 1/1 for 40; element [0][1] alternating (1,0),(0,1) -> acc[1][1]=-60, acc[0][1]=0.
- Saturation, ACC_W=4, len=20, constant (1,0) -> acc=+7; constant (0,1) -> acc=-7.
- start pulsed during RUN and ack pulsed during RUN -> no effect on count or timing; start with len=0 -> done next cycle with acc=0; in DONE, start and ack together -> IDLE, no new window.
- RST asserted mid-RUN at cycle 5 of len=50 -> next cycle IDLE, acc=0, sub_nrst=0; a fresh start with len=4 then completes normally.
